// File: rtl/connect4_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : connect4_pkg
// Brief    : Shared types and constants for the 4x4 Connect-4 turn controller
//            (FSM encoding, board geometry, winner codes, column decoder).
// Revision : 1.0 - initial release
// ============================================================================
package connect4_pkg;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int CELLS = ROWS * COLS;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_DROP  = 3'd2,
    ST_EVAL  = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P0   = 2'b01;
  localparam logic [1:0] WIN_P1   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } col_dec_t;

  // Active-low one-hot column select; anything other than a single zero is invalid.
  function automatic col_dec_t decode_column(input logic [COLS-1:0] sel);
    col_dec_t d;
    d.valid = 1'b1;
    d.idx   = 2'd0;
    case (sel)
      4'b1110: d.idx = 2'd0;
      4'b1101: d.idx = 2'd1;
      4'b1011: d.idx = 2'd2;
      4'b0111: d.idx = 2'd3;
      default: d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/connect4_win_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : connect4_win_checker
// Brief    : Combinational four-in-a-line detector over one player's cell mask
//            (4 rows, 4 columns, 2 diagonals).
// Revision : 1.0 - initial release
// ============================================================================
module connect4_win_checker
  import connect4_pkg::*;
(
  input  logic [CELLS-1:0] player_mask,
  output logic             win
);

  localparam int NLINES = 10;

  // Bit n of a mask is cell n = row*4+col, row 0 at the bottom.
  localparam logic [NLINES-1:0][CELLS-1:0] LINE_MASKS = {
    16'h1248,  // anti-diagonal: cells 3,6,9,12
    16'h8421,  // diagonal: cells 0,5,10,15
    16'h8888,  // column 3
    16'h4444,  // column 2
    16'h2222,  // column 1
    16'h1111,  // column 0
    16'hF000,  // row 3
    16'h0F00,  // row 2
    16'h00F0,  // row 1
    16'h000F   // row 0
  };

  logic [NLINES-1:0] line_hit;

  for (genvar i = 0; i < NLINES; i++) begin : g_line
    assign line_hit[i] = ((player_mask & LINE_MASKS[i]) == LINE_MASKS[i]);
  end

  assign win = |line_hit;

endmodule
`default_nettype wire

// File: rtl/connect4_turn_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : connect4_turn_controller
// Brief    : Turn sequencing for a 4x4 Connect-4 board: accepts a column move,
//            drops the piece, animates for DROP_CYCLES, evaluates win/draw and
//            hands the turn over.
// Revision : 1.0 - initial release
// ============================================================================
module connect4_turn_controller
  import connect4_pkg::*;
#(
  parameter int DROP_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             new_game,
  input  logic             move_valid,
  input  logic [COLS-1:0]  selected_column,
  output logic             move_ready,
  output logic             current_player,
  output logic             cell_we,
  output logic [3:0]       cell_addr,
  output logic             cell_player,
  output logic             invalid_column,
  output logic             game_over,
  output logic [1:0]       winner,
  output logic [CELLS-1:0] board_occ,
  output logic [CELLS-1:0] board_owner
);

  state_e                  state_q, state_d;
  logic                    player_q, player_d;
  logic [COLS-1:0]         col_q, col_d;
  logic [COLS-1:0][2:0]    fill_q, fill_d;
  logic [CELLS-1:0]        occ_q, occ_d;
  logic [CELLS-1:0]        own_q, own_d;
  logic [1:0]              winner_q, winner_d;
  logic [3:0]              drop_cnt_q, drop_cnt_d;

  col_dec_t                dec;
  logic [2:0]              fill_sel;
  logic                    move_ok;
  logic [3:0]              wr_addr;
  logic [CELLS-1:0]        player_mask;
  logic                    line_win;

  // Decode the captured column and locate the landing cell.
  assign dec         = decode_column(col_q);
  assign fill_sel    = fill_q[dec.idx];
  assign move_ok     = dec.valid && (fill_sel != 3'(ROWS));
  assign wr_addr     = {fill_sel[1:0], dec.idx};
  assign player_mask = occ_q & (player_q ? own_q : ~own_q);

  connect4_win_checker u_win_checker (
    .player_mask (player_mask),
    .win         (line_win)
  );

  // State register; reset aborts any move in flight with no board update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      player_q   <= 1'b0;
      col_q      <= '0;
      fill_q     <= '0;
      occ_q      <= '0;
      own_q      <= '0;
      winner_q   <= WIN_NONE;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      player_q   <= player_d;
      col_q      <= col_d;
      fill_q     <= fill_d;
      occ_q      <= occ_d;
      own_q      <= own_d;
      winner_q   <= winner_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Next-state logic and per-cycle strobes; new_game overrides everything.
  always_comb begin
    state_d        = state_q;
    player_d       = player_q;
    col_d          = col_q;
    fill_d         = fill_q;
    occ_d          = occ_q;
    own_d          = own_q;
    winner_d       = winner_q;
    drop_cnt_d     = drop_cnt_q;
    cell_we        = 1'b0;
    cell_addr      = '0;
    cell_player    = 1'b0;
    invalid_column = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (move_valid) begin
          // The column is latched here and never looked at again.
          col_d   = selected_column;
          state_d = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (move_ok) begin
          cell_we             = 1'b1;
          cell_addr           = wr_addr;
          cell_player         = player_q;
          occ_d[wr_addr]      = 1'b1;
          own_d[wr_addr]      = player_q;
          fill_d[dec.idx]     = fill_sel + 3'd1;
          drop_cnt_d          = '0;
          state_d             = ST_DROP;
        end else begin
          invalid_column = 1'b1;
          state_d        = ST_IDLE;
        end
      end

      ST_DROP: begin
        if (drop_cnt_q == 4'(DROP_CYCLES - 1)) begin
          state_d = ST_EVAL;
        end else begin
          drop_cnt_d = drop_cnt_q + 4'd1;
        end
      end

      ST_EVAL: begin
        if (line_win) begin
          winner_d = player_q ? WIN_P1 : WIN_P0;
          state_d  = ST_OVER;
        end else if (&occ_q) begin
          winner_d = WIN_DRAW;
          state_d  = ST_OVER;
        end else begin
          player_d = ~player_q;
          state_d  = ST_IDLE;
        end
      end

      ST_OVER: begin
        // Frozen until new_game or reset.
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (new_game) begin
      // The board is about to be wiped, so no write or reject is announced.
      cell_we        = 1'b0;
      cell_addr      = '0;
      cell_player    = 1'b0;
      invalid_column = 1'b0;
      state_d        = ST_IDLE;
      player_d       = 1'b0;
      col_d          = '0;
      fill_d         = '0;
      occ_d          = '0;
      own_d          = '0;
      winner_d       = WIN_NONE;
      drop_cnt_d     = '0;
    end
  end

  assign move_ready     = (state_q == ST_IDLE);
  assign game_over      = (state_q == ST_OVER);
  assign current_player = player_q;
  assign winner         = winner_q;
  assign board_occ      = occ_q;
  assign board_owner    = own_q;

endmodule
`default_nettype wire

// File: tb/tb_connect4_turn_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_connect4_turn_controller
// Brief    : Self-checking bench for connect4_turn_controller with a board
//            model and a strobe scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_connect4_turn_controller;

  localparam int DROP_CYCLES = 4;
  localparam int TIMEOUT     = 40;

  logic        clk;
  logic        rst_n;
  logic        new_game;
  logic        move_valid;
  logic [3:0]  selected_column;
  logic        move_ready;
  logic        current_player;
  logic        cell_we;
  logic [3:0]  cell_addr;
  logic        cell_player;
  logic        invalid_column;
  logic        game_over;
  logic [1:0]  winner;
  logic [15:0] board_occ;
  logic [15:0] board_owner;

  connect4_turn_controller #(.DROP_CYCLES(DROP_CYCLES)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .new_game        (new_game),
    .move_valid      (move_valid),
    .selected_column (selected_column),
    .move_ready      (move_ready),
    .current_player  (current_player),
    .cell_we         (cell_we),
    .cell_addr       (cell_addr),
    .cell_player     (cell_player),
    .invalid_column  (invalid_column),
    .game_over       (game_over),
    .winner          (winner),
    .board_occ       (board_occ),
    .board_owner     (board_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       is_invalid;
    logic [3:0] addr;
    logic       player;
  } evt_t;

  evt_t exp_q[$];
  evt_t mon_e;

  // Reference model of the board and turn state.
  logic [15:0] m_occ;
  logic [15:0] m_own;
  int          m_fill [4];
  logic        m_player;
  logic [1:0]  m_winner;
  logic        m_over;

  task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic bit model_has_line(input logic [15:0] m);
    bit hit;
    hit = 1'b0;
    for (int r = 0; r < 4; r++)
      if (m[r*4] && m[r*4+1] && m[r*4+2] && m[r*4+3]) hit = 1'b1;
    for (int c = 0; c < 4; c++)
      if (m[c] && m[4+c] && m[8+c] && m[12+c]) hit = 1'b1;
    if (m[0] && m[5] && m[10] && m[15]) hit = 1'b1;
    if (m[3] && m[6] && m[9] && m[12]) hit = 1'b1;
    return hit;
  endfunction

  task automatic model_clear();
    m_occ    = '0;
    m_own    = '0;
    for (int i = 0; i < 4; i++) m_fill[i] = 0;
    m_player = 1'b0;
    m_winner = 2'b00;
    m_over   = 1'b0;
  endtask

  // Scoreboard consumer: every write/reject strobe must match the next expected event.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (cell_we === 1'b1 || invalid_column === 1'b1)) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_strobe", {30'd0, cell_we, invalid_column}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("strobe_kind", {30'd0, cell_we, invalid_column},
                 mon_e.is_invalid ? 32'd1 : 32'd2);
        if (!mon_e.is_invalid) begin
          check_eq("cell_addr", cell_addr, mon_e.addr);
          check_eq("cell_player", cell_player, mon_e.player);
        end
      end
    end
  end

  task automatic check_board();
    check_eq("board_occ", board_occ, m_occ);
    check_eq("board_owner", board_owner, m_own);
  endtask

  task automatic check_idle_clear();
    check_board();
    check_eq("player_after_clear", current_player, 1'b0);
    check_eq("winner_after_clear", winner, 2'b00);
    check_eq("ready_after_clear", move_ready, 1'b1);
    check_eq("over_after_clear", game_over, 1'b0);
  endtask

  // Predicts the CHECK outcome and pushes the expected strobe.
  task automatic predict_move(input logic [3:0] sel, output bit valid);
    int   col;
    evt_t e;
    case (sel)
      4'b1110: col = 0;
      4'b1101: col = 1;
      4'b1011: col = 2;
      4'b0111: col = 3;
      default: col = -1;
    endcase
    e = '0;
    if (col >= 0 && m_fill[col] < 4) begin
      valid        = 1'b1;
      e.is_invalid = 1'b0;
      e.addr       = 4'(m_fill[col] * 4 + col);
      e.player     = m_player;
      m_occ[e.addr] = 1'b1;
      m_own[e.addr] = m_player;
      m_fill[col]++;
    end else begin
      valid        = 1'b0;
      e.is_invalid = 1'b1;
    end
    exp_q.push_back(e);
  endtask

  task automatic predict_eval(output bit ends);
    logic [15:0] pm;
    pm   = m_occ & (m_player ? m_own : ~m_own);
    ends = 1'b1;
    if (model_has_line(pm))    m_winner = m_player ? 2'b10 : 2'b01;
    else if (m_occ == 16'hFFFF) m_winner = 2'b11;
    else begin
      m_player = ~m_player;
      ends     = 1'b0;
    end
    m_over = ends;
  endtask

  // Presents a move and returns just after the accepting edge.
  task automatic accept_move(input logic [3:0] sel);
    @(negedge clk);
    check_eq("ready_before_move", move_ready, 1'b1);
    move_valid      = 1'b1;
    selected_column = sel;
    @(posedge clk);
    #1;
    move_valid      = 1'b0;
    selected_column = 4'b1111;  // would be rejected if the DUT re-sampled it
  endtask

  task automatic do_move(input logic [3:0] sel);
    bit valid;
    bit ends;
    int lat;
    predict_move(sel, valid);
    ends = 1'b0;
    if (valid) predict_eval(ends);
    accept_move(sel);
    lat = 1;
    while (lat <= TIMEOUT) begin
      @(negedge clk);
      if (move_ready || game_over) break;
      lat++;
    end
    check_eq("move_latency", lat, valid ? DROP_CYCLES + 3 : 2);
    check_board();
    check_eq("game_over", game_over, ends);
    check_eq("winner", winner, m_winner);
    check_eq("current_player", current_player, m_player);
    check_eq("move_ready", move_ready, !ends);
  endtask

  task automatic start_new_game();
    @(negedge clk);
    new_game = 1'b1;
    @(posedge clk);
    #1;
    new_game = 1'b0;
    model_clear();
    @(negedge clk);
    check_idle_clear();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit          valid;
    logic [15:0] occ_hold;
    logic [3:0]  win_seq  [7]  = '{4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1011, 4'b1011, 4'b0111};
    logic [3:0]  draw_cols[16] = '{4'b1110, 4'b1011, 4'b1101, 4'b0111,
                                   4'b1011, 4'b1110, 4'b0111, 4'b1101,
                                   4'b1110, 4'b1011, 4'b1101, 4'b0111,
                                   4'b1011, 4'b1110, 4'b0111, 4'b1101};

    rst_n           = 1'b0;
    new_game        = 1'b0;
    move_valid      = 1'b0;
    selected_column = 4'b1111;
    model_clear();

    // Reset values.
    repeat (3) @(negedge clk);
    check_eq("rst_move_ready", move_ready, 1'b1);
    check_eq("rst_cell_we", cell_we, 1'b0);
    check_eq("rst_invalid", invalid_column, 1'b0);
    check_eq("rst_game_over", game_over, 1'b0);
    check_eq("rst_winner", winner, 2'b00);
    check_eq("rst_player", current_player, 1'b0);
    check_eq("rst_cell_addr", cell_addr, 4'd0);
    check_eq("rst_cell_player", cell_player, 1'b0);
    check_board();
    rst_n = 1'b1;

    // First move into column 0.
    do_move(4'b1110);

    // Fill column 2, then overflow it.
    start_new_game();
    for (int i = 0; i < 5; i++) do_move(4'b1011);

    // Malformed column selects.
    do_move(4'b1100);
    do_move(4'b1111);

    // P0 completes the bottom row.
    start_new_game();
    for (int i = 0; i < 7; i++) do_move(win_seq[i]);
    occ_hold = board_occ;
    @(negedge clk);
    move_valid      = 1'b1;
    selected_column = 4'b1101;
    repeat (10) @(negedge clk);
    move_valid      = 1'b0;
    check_eq("over_board_stable", board_occ, occ_hold);
    check_eq("over_game_over", game_over, 1'b1);
    check_eq("over_winner", winner, 2'b01);
    check_eq("over_not_ready", move_ready, 1'b0);
    start_new_game();

    // Full board without any line of four.
    for (int i = 0; i < 16; i++) do_move(draw_cols[i]);
    start_new_game();

    // new_game in the middle of DROP.
    predict_move(4'b1110, valid);
    accept_move(4'b1110);
    repeat (2) @(negedge clk);
    check_eq("in_drop_not_ready", move_ready, 1'b0);
    new_game = 1'b1;
    @(posedge clk);
    #1;
    new_game = 1'b0;
    model_clear();
    repeat (DROP_CYCLES + 4) @(negedge clk);
    check_idle_clear();

    // Reset asserted while the move sits in CHECK.
    accept_move(4'b1101);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_ready", move_ready, 1'b1);
    check_eq("rst_mid_we", cell_we, 1'b0);
    rst_n = 1'b1;
    model_clear();
    repeat (DROP_CYCLES + 4) @(negedge clk);
    check_idle_clear();

    // new_game wins over a simultaneous accept.
    @(negedge clk);
    move_valid      = 1'b1;
    selected_column = 4'b1110;
    new_game        = 1'b1;
    @(posedge clk);
    #1;
    move_valid      = 1'b0;
    new_game        = 1'b0;
    selected_column = 4'b1111;
    repeat (DROP_CYCLES + 4) @(negedge clk);
    check_idle_clear();

    // Controller still operates normally afterwards.
    do_move(4'b0111);

    check_eq("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
